// File: rtl/fft_pkg.sv
// Types and constants shared by the FFT readout blocks.
// The cplx_t layout (re in the upper half) must match the FFT RAM word layout.
package fft_pkg;

    localparam int FFT_W       = 14;
    localparam int FFT_ADDR_W  = 10;
    localparam int NCH_DEFAULT = 4;

    typedef struct packed {
        logic signed [FFT_W-1:0] re;
        logic signed [FFT_W-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ1,
        ST_READ2,
        ST_LATCH,
        ST_MUL,
        ST_SUM
    } bincorr_state_t;

endpackage

// File: rtl/bincorr_cmult_conj.sv
// Registered partial products for x * conj(y): the caller forms re = ac + bd, im = bc - ad.
module cmult_conj
    import fft_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  cplx_t                     x_i,
    input  cplx_t                     y_i,
    output logic signed [2*FFT_W-1:0] ac_o,
    output logic signed [2*FFT_W-1:0] bd_o,
    output logic signed [2*FFT_W-1:0] bc_o,
    output logic signed [2*FFT_W-1:0] ad_o
);

    logic signed [2*FFT_W-1:0] a_ext, b_ext, c_ext, d_ext;
    logic signed [2*FFT_W-1:0] ac_q, bd_q, bc_q, ad_q;

    // Widen before multiplying so the full 2W-bit signed product is kept.
    assign a_ext = (2*FFT_W)'($signed(x_i.re));
    assign b_ext = (2*FFT_W)'($signed(x_i.im));
    assign c_ext = (2*FFT_W)'($signed(y_i.re));
    assign d_ext = (2*FFT_W)'($signed(y_i.im));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac_q <= '0;
            bd_q <= '0;
            bc_q <= '0;
            ad_q <= '0;
        end else if (en_i) begin
            ac_q <= a_ext * c_ext;
            bd_q <= b_ext * d_ext;
            bc_q <= b_ext * c_ext;
            ad_q <= a_ext * d_ext;
        end
    end

    assign ac_o = ac_q;
    assign bd_o = bd_q;
    assign bc_o = bc_q;
    assign ad_o = ad_q;

endmodule

// File: rtl/bincorr.sv
// Reads the detected peak bin from every channel and forms X0 * conj(Xk) for k = 1..NCH-1.
// One conjugate multiplier is time-shared across channels: MUL/SUM per k.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | wait for detectdone rise, hold last results
// READ1    | first RAM latency cycle
// READ2    | second RAM latency cycle
// LATCH    | capture all channel words, k <= 1
// MUL      | register the four products for channel k
// SUM      | write result k; finish or advance k
module bincorr
    import fft_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int W   = FFT_W
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      detectdone,
    input  logic [FFT_ADDR_W-1:0]     maxbin,
    input  logic [NCH-1:0][2*W-1:0]   ramq,
    output logic [FFT_ADDR_W-1:0]     ramaddr,
    output logic [FFT_ADDR_W-1:0]     binout,
    output logic [NCH-2:0][2*W:0]     corr_re,
    output logic [NCH-2:0][2*W:0]     corr_im,
    output logic                      corrdone
);

    localparam int K_W = $clog2(NCH);

    bincorr_state_t state_q, state_d;

    logic                  dd_q;
    logic [K_W-1:0]        k_q;
    logic [K_W-1:0]        k_idx;
    logic [FFT_ADDR_W-1:0] ramaddr_q, binout_q;
    logic [NCH-2:0][2*W:0] corr_re_q, corr_im_q;
    logic                  corrdone_q;
    cplx_t                 lat_q [NCH];

    logic start, latch_en, mul_en, sum_en, last_k;

    logic signed [2*W-1:0] ac, bd, bc, ad;
    logic signed [2*W:0]   sum_re, sum_im;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ1;
            ST_READ1: state_d = ST_READ2;
            ST_READ2: state_d = ST_LATCH;
            ST_LATCH: state_d = ST_MUL;
            ST_MUL:   state_d = ST_SUM;
            ST_SUM:   state_d = last_k ? ST_IDLE : ST_MUL;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start    = (state_q == ST_IDLE) && detectdone && !dd_q;
        latch_en = (state_q == ST_LATCH);
        mul_en   = (state_q == ST_MUL);
        sum_en   = (state_q == ST_SUM);
        last_k   = (k_q == K_W'(NCH-1));
    end

    cmult_conj u_cmult (
        .clk   (clk),
        .reset (reset),
        .en_i  (mul_en),
        .x_i   (lat_q[0]),
        .y_i   (lat_q[k_q]),
        .ac_o  (ac),
        .bd_o  (bd),
        .bc_o  (bc),
        .ad_o  (ad)
    );

    assign sum_re = (2*W+1)'(ac) + (2*W+1)'(bd);
    assign sum_im = (2*W+1)'(bc) - (2*W+1)'(ad);
    assign k_idx  = k_q - K_W'(1);

    // dd_q resets high so a level already present at reset release is not a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dd_q       <= 1'b1;
            k_q        <= '0;
            ramaddr_q  <= '0;
            binout_q   <= '0;
            corr_re_q  <= '0;
            corr_im_q  <= '0;
            corrdone_q <= 1'b0;
            for (int c = 0; c < NCH; c++) lat_q[c] <= '0;
        end else begin
            dd_q <= detectdone;
            if (start) begin
                ramaddr_q  <= maxbin;
                binout_q   <= maxbin;
                corrdone_q <= 1'b0;
            end
            if (latch_en) begin
                for (int c = 0; c < NCH; c++) lat_q[c] <= cplx_t'(ramq[c]);
                k_q <= K_W'(1);
            end
            if (sum_en) begin
                corr_re_q[k_idx] <= sum_re;
                corr_im_q[k_idx] <= sum_im;
                if (last_k) begin
                    corrdone_q <= 1'b1;
                end else begin
                    k_q <= k_q + K_W'(1);
                end
            end
        end
    end

    assign ramaddr  = ramaddr_q;
    assign binout   = binout_q;
    assign corr_re  = corr_re_q;
    assign corr_im  = corr_im_q;
    assign corrdone = corrdone_q;

endmodule

// File: tb/tb_bincorr.sv
// Directed bench for bincorr: NCH=4 main instance plus an NCH=2 instance.
module tb_bincorr;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic detectdone, dd2;
    logic [9:0] maxbin;

    logic [3:0][27:0] ramq;
    logic [9:0]       ramaddr, binout;
    logic [2:0][28:0] corr_re, corr_im;
    logic             corrdone;

    logic [1:0][27:0] ramq2;
    logic [9:0]       ramaddr2, binout2;
    logic [0:0][28:0] corr_re2, corr_im2;
    logic             corrdone2;

    int errors = 0;
    int checks = 0;
    int exp_re[3];
    int exp_im[3];

    always #10 clk = ~clk;

    bincorr #(.NCH(4), .W(14)) dut (
        .clk(clk), .reset(reset), .detectdone(detectdone), .maxbin(maxbin),
        .ramq(ramq), .ramaddr(ramaddr), .binout(binout),
        .corr_re(corr_re), .corr_im(corr_im), .corrdone(corrdone)
    );

    bincorr #(.NCH(2), .W(14)) dut2 (
        .clk(clk), .reset(reset), .detectdone(dd2), .maxbin(maxbin),
        .ramq(ramq2), .ramaddr(ramaddr2), .binout(binout2),
        .corr_re(corr_re2), .corr_im(corr_im2), .corrdone(corrdone2)
    );

    function automatic logic [27:0] mk(input int re, input int im);
        return {re[13:0], im[13:0]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves detectdone freshly high at a negedge; the next posedge is t0.
    task automatic rise_dd();
        detectdone = 1'b0;
        cyc(2);
        detectdone = 1'b1;
    endtask

    task automatic load_basic();
        ramq[0] = mk(100, 50);
        ramq[1] = mk(100, 50);
        ramq[2] = mk(0, 100);
        ramq[3] = mk(-100, -50);
        exp_re = '{12500, 5000, -12500};
        exp_im = '{0, -10000, 0};
    endtask

    task automatic load_full();
        ramq[0] = mk(-8192, -8192);
        ramq[1] = mk(-8192, -8192);
        ramq[2] = mk(0, 0);
        ramq[3] = mk(-8192, 8191);
        exp_re = '{134217728, 0, 8192};
        exp_im = '{0, 0, 134209536};
    endtask

    task automatic test_reset();
        logic signed [28:0] got;
        reset = 1'b1; detectdone = 1'b0; dd2 = 1'b0; maxbin = '0; ramq = '0; ramq2 = '0;
        cyc(2);
        checks++; if (ramaddr !== 10'h0) begin errors++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
        checks++; if (binout !== 10'h0) begin errors++; $display("FAIL reset_binout got=%h exp=0", binout); end
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL reset_corrdone got=%b exp=0", corrdone); end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== 29'sd0) begin errors++; $display("FAIL reset_corr_re[%0d] got=%0d exp=0", k, got); end
            got = corr_im[k];
            checks++; if (got !== 29'sd0) begin errors++; $display("FAIL reset_corr_im[%0d] got=%0d exp=0", k, got); end
        end
        checks++; if (corrdone2 !== 1'b0) begin errors++; $display("FAIL reset_corrdone2 got=%b exp=0", corrdone2); end
        reset = 1'b0;
        cyc(2);
    endtask

    task automatic test_basic();
        logic signed [28:0] got;
        load_basic();
        maxbin = 10'h155;
        rise_dd();
        for (int i = 0; i <= 9; i++) begin
            cyc(1);
            if (i == 0) begin
                checks++; if (ramaddr !== 10'h155) begin errors++; $display("FAIL basic_ramaddr got=%h exp=155", ramaddr); end
                checks++; if (binout !== 10'h155) begin errors++; $display("FAIL basic_binout got=%h exp=155", binout); end
            end
            if (i == 5) begin
                got = corr_re[0];
                checks++; if (got !== 29'sd12500) begin errors++; $display("FAIL basic_corr0_at_t5 got=%0d exp=12500", got); end
                got = corr_re[1];
                checks++; if (got !== 29'sd0) begin errors++; $display("FAIL basic_corr1_early got=%0d exp=0", got); end
            end
            if (i == 8) begin
                checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL basic_corrdone_t8 got=%b exp=0", corrdone); end
            end
            if (i == 9) begin
                checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL basic_corrdone_t9 got=%b exp=1", corrdone); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== exp_re[k]) begin errors++; $display("FAIL basic_corr_re[%0d] got=%0d exp=%0d", k, got, exp_re[k]); end
            got = corr_im[k];
            checks++; if (got !== exp_im[k]) begin errors++; $display("FAIL basic_corr_im[%0d] got=%0d exp=%0d", k, got, exp_im[k]); end
        end
    endtask

    task automatic test_fullscale();
        logic signed [28:0] got;
        load_full();
        maxbin = 10'h3FF;
        rise_dd();
        cyc(1);
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL full_corrdone_t0 got=%b exp=0", corrdone); end
        cyc(9);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL full_corrdone_t9 got=%b exp=1", corrdone); end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== exp_re[k]) begin errors++; $display("FAIL full_corr_re[%0d] got=%0d exp=%0d", k, got, exp_re[k]); end
            got = corr_im[k];
            checks++; if (got !== exp_im[k]) begin errors++; $display("FAIL full_corr_im[%0d] got=%0d exp=%0d", k, got, exp_im[k]); end
        end
    endtask

    task automatic test_retrigger();
        logic signed [28:0] got;
        cyc(50);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL hold_corrdone got=%b exp=1", corrdone); end
        got = corr_re[0];
        checks++; if (got !== 29'sd134217728) begin errors++; $display("FAIL hold_corr_re0 got=%0d exp=134217728", got); end
        checks++; if (ramaddr !== 10'h3FF) begin errors++; $display("FAIL hold_ramaddr got=%h exp=3ff", ramaddr); end
        load_basic();
        maxbin = 10'h0AB;
        rise_dd();
        cyc(1);
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL retrig_corrdone_t0 got=%b exp=0", corrdone); end
        checks++; if (ramaddr !== 10'h0AB) begin errors++; $display("FAIL retrig_ramaddr got=%h exp=0ab", ramaddr); end
        cyc(8);
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL retrig_corrdone_t8 got=%b exp=0", corrdone); end
        cyc(1);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL retrig_corrdone_t9 got=%b exp=1", corrdone); end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== exp_re[k]) begin errors++; $display("FAIL retrig_corr_re[%0d] got=%0d exp=%0d", k, got, exp_re[k]); end
            got = corr_im[k];
            checks++; if (got !== exp_im[k]) begin errors++; $display("FAIL retrig_corr_im[%0d] got=%0d exp=%0d", k, got, exp_im[k]); end
        end
    endtask

    task automatic test_pulse_midpass();
        logic signed [28:0] got;
        load_full();
        maxbin = 10'h3FF;
        rise_dd();
        cyc(1);
        detectdone = 1'b0;
        cyc(3);
        detectdone = 1'b1;
        cyc(2);
        detectdone = 1'b0;
        cyc(4);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL pulse_corrdone_t9 got=%b exp=1", corrdone); end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== exp_re[k]) begin errors++; $display("FAIL pulse_corr_re[%0d] got=%0d exp=%0d", k, got, exp_re[k]); end
            got = corr_im[k];
            checks++; if (got !== exp_im[k]) begin errors++; $display("FAIL pulse_corr_im[%0d] got=%0d exp=%0d", k, got, exp_im[k]); end
        end
        cyc(12);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL pulse_no_second_pass got=%b exp=1", corrdone); end
    endtask

    task automatic test_reset_midpass();
        logic signed [28:0] got;
        load_basic();
        maxbin = 10'h155;
        rise_dd();
        cyc(6);
        reset = 1'b1;
        #1;
        checks++; if (ramaddr !== 10'h0) begin errors++; $display("FAIL abort_ramaddr got=%h exp=0", ramaddr); end
        checks++; if (binout !== 10'h0) begin errors++; $display("FAIL abort_binout got=%h exp=0", binout); end
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL abort_corrdone got=%b exp=0", corrdone); end
        got = corr_re[0];
        checks++; if (got !== 29'sd0) begin errors++; $display("FAIL abort_corr_re0 got=%0d exp=0", got); end
        cyc(2);
        reset = 1'b0;
        cyc(15);
        checks++; if (corrdone !== 1'b0) begin errors++; $display("FAIL held_release_corrdone got=%b exp=0", corrdone); end
        checks++; if (ramaddr !== 10'h0) begin errors++; $display("FAIL held_release_ramaddr got=%h exp=0", ramaddr); end
        rise_dd();
        cyc(10);
        checks++; if (corrdone !== 1'b1) begin errors++; $display("FAIL after_abort_corrdone got=%b exp=1", corrdone); end
        checks++; if (ramaddr !== 10'h155) begin errors++; $display("FAIL after_abort_ramaddr got=%h exp=155", ramaddr); end
        for (int k = 0; k < 3; k++) begin
            got = corr_re[k];
            checks++; if (got !== exp_re[k]) begin errors++; $display("FAIL after_abort_corr_re[%0d] got=%0d exp=%0d", k, got, exp_re[k]); end
            got = corr_im[k];
            checks++; if (got !== exp_im[k]) begin errors++; $display("FAIL after_abort_corr_im[%0d] got=%0d exp=%0d", k, got, exp_im[k]); end
        end
    endtask

    task automatic test_nch2();
        logic signed [28:0] got;
        ramq2[0] = mk(100, 50);
        ramq2[1] = mk(0, 100);
        maxbin = 10'h201;
        dd2 = 1'b0;
        cyc(2);
        dd2 = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            cyc(1);
            if (i == 0) begin
                checks++; if (binout2 !== 10'h201) begin errors++; $display("FAIL nch2_binout got=%h exp=201", binout2); end
            end
            if (i == 4) begin
                checks++; if (corrdone2 !== 1'b0) begin errors++; $display("FAIL nch2_corrdone_t4 got=%b exp=0", corrdone2); end
            end
            if (i == 5) begin
                checks++; if (corrdone2 !== 1'b1) begin errors++; $display("FAIL nch2_corrdone_t5 got=%b exp=1", corrdone2); end
            end
        end
        got = corr_re2[0];
        checks++; if (got !== 29'sd5000) begin errors++; $display("FAIL nch2_corr_re got=%0d exp=5000", got); end
        got = corr_im2[0];
        checks++; if (got !== -29'sd10000) begin errors++; $display("FAIL nch2_corr_im got=%0d exp=-10000", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fullscale();
        test_retrigger();
        test_pulse_midpass();
        test_reset_midpass();
        test_nch2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
